// File: rtl/wave_display_pkg.sv
// Shared types and constants for the waveform display reader: FSM encoding,
// display-quadrant geometry and default trace/grid colors.
package wave_display_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } state_e;

  // Top-right quadrant: x in 512..1023, y in the upper half of the frame.
  localparam logic [1:0] REGION_X_QUAD = 2'b01;
  localparam logic       REGION_Y_HALF = 1'b0;

  localparam logic [23:0] DEFAULT_WAVE_COLOR = 24'hFFFFFF;
  localparam logic [23:0] DEFAULT_GRID_COLOR = 24'h404040;

  function automatic logic in_region(input logic valid, input logic [10:0] x, input logic [9:0] y);
    return valid && (x[10:9] == REGION_X_QUAD) && (y[9] == REGION_Y_HALF);
  endfunction

endpackage

// File: rtl/wave_display_if.sv
// Raster, sample-RAM read port and pixel output bundle of the waveform display.
// The slave side is the display block; the master side is raster/RAM/sink.
interface wave_display_if;

  logic [10:0] x;
  logic [9:0]  y;
  logic        valid;
  logic        read_index;
  logic [7:0]  read_value;
  logic [8:0]  read_address;
  logic        valid_pixel;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;
  logic        wave_display_idle;

  modport master (
    output x, y, valid, read_index, read_value,
    input  read_address, valid_pixel, r, g, b, wave_display_idle
  );

  modport slave (
    input  x, y, valid, read_index, read_value,
    output read_address, valid_pixel, r, g, b, wave_display_idle
  );

endinterface

// File: rtl/dffr.sv
// Register with synchronous active-high reset to zero.
module dffr #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             r,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // reset-dominant storage
  always_ff @(posedge clk) begin
    if (r) begin
      q <= {WIDTH{1'b0}};
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/dffre.sv
// Register with synchronous active-high reset to zero and load enable.
module dffre #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             r,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // reset-dominant storage, loads only when enabled
  always_ff @(posedge clk) begin
    if (r) begin
      q <= {WIDTH{1'b0}};
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/wave_display_span_cmp.sv
// Decides whether a display row lies on the vertical segment joining two
// consecutive samples (inclusive, unsigned 8-bit).
module wave_display_span_cmp (
  input  logic [7:0] prev,
  input  logic [7:0] cur,
  input  logic [7:0] row,
  output logic       hit
);

  logic [7:0] lo_s;
  logic [7:0] hi_s;

  // order the segment endpoints
  always_comb begin
    if (prev <= cur) begin
      lo_s = prev;
      hi_s = cur;
    end else begin
      lo_s = cur;
      hi_s = prev;
    end
  end

  assign hit = (row >= lo_s) && (row <= hi_s);

endmodule

// File: rtl/wave_display.sv
// Waveform display reader: scans the idle sample buffer along with the raster
// and draws a connected trace in the top-right quadrant. WAVE_DISPLAY_GRID_EN adds a grid.
module wave_display
  import wave_display_pkg::*;
#(
  parameter logic [23:0] WAVE_COLOR = DEFAULT_WAVE_COLOR,
  parameter logic [23:0] GRID_COLOR = DEFAULT_GRID_COLOR
) (
  input  logic          clk,
  input  logic          reset,
  wave_display_if.slave bus
);

  logic       state_r;
  state_e     state_next_s;
  logic       buf_r;
  logic       buf_next_s;
  logic       region0_s;
  logic       leave_s;
  logic [8:0] read_address_s;

  logic       region1_r;
  logic       valid1_r;
  logic [7:0] col1_r;
  logic [7:0] row1_r;
  logic [7:0] cur_s;
  logic [7:0] cur_r;
  logic [7:0] last_col_r;
  logic [7:0] prev_r;
  logic [7:0] prev_s;
  logic       span_hit_s;
  logic [23:0] color_s;
  logic [23:0] color_r;
  logic       valid_pixel_r;

  assign region0_s = in_region(bus.valid, bus.x, bus.y);
  assign leave_s   = bus.valid && (bus.y[9] != REGION_Y_HALF);

  dffr #(.WIDTH(1)) u_state (.clk(clk), .r(reset), .d(state_next_s), .q(state_r));
  dffr #(.WIDTH(1)) u_buf   (.clk(clk), .r(reset), .d(buf_next_s),   .q(buf_r));

  // next-state: enter on the first visible quadrant pixel, leave on the lower half
  always_comb begin
    state_next_s = IDLE;
    case (state_e'(state_r))
      IDLE: begin
        if (region0_s) state_next_s = DRAW;
        else           state_next_s = IDLE;
      end
      DRAW: begin
        if (leave_s) state_next_s = IDLE;
        else         state_next_s = DRAW;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // buffer select is latched on entry so the first column already reads the new buffer
  always_comb begin
    buf_next_s     = buf_r;
    read_address_s = {buf_r, 8'd0};
    if ((state_e'(state_r) == IDLE) && region0_s) begin
      buf_next_s = ~bus.read_index;
    end else begin
      buf_next_s = buf_r;
    end
    if (state_next_s == DRAW) begin
      read_address_s = {buf_next_s, bus.x[8:1]};
    end else begin
      read_address_s = {buf_next_s, 8'd0};
    end
  end

  assign bus.read_address      = read_address_s;
  assign bus.wave_display_idle = (state_e'(state_r) == IDLE);

  dffr #(.WIDTH(1)) u_region1 (.clk(clk), .r(reset), .d(region0_s),   .q(region1_r));
  dffr #(.WIDTH(1)) u_valid1  (.clk(clk), .r(reset), .d(bus.valid),   .q(valid1_r));
  dffr #(.WIDTH(8)) u_col1    (.clk(clk), .r(reset), .d(bus.x[8:1]),  .q(col1_r));
  dffr #(.WIDTH(8)) u_row1    (.clk(clk), .r(reset), .d(bus.y[8:1]),  .q(row1_r));

  // Offset-binary sample inverted so larger values sit nearer the top of the screen.
  assign cur_s = ~bus.read_value;

  // previous sample follows the column; column 0 restarts the trace to avoid a wrap line
  always_comb begin
    prev_s = prev_r;
    if (col1_r == 8'd0) begin
      prev_s = cur_s;
    end else if (col1_r != last_col_r) begin
      prev_s = cur_r;
    end else begin
      prev_s = prev_r;
    end
  end

  dffre #(.WIDTH(8)) u_cur      (.clk(clk), .r(reset), .en(region1_r), .d(cur_s),  .q(cur_r));
  dffre #(.WIDTH(8)) u_last_col (.clk(clk), .r(reset), .en(region1_r), .d(col1_r), .q(last_col_r));
  dffre #(.WIDTH(8)) u_prev     (.clk(clk), .r(reset), .en(region1_r), .d(prev_s), .q(prev_r));

  wave_display_span_cmp u_span (
    .prev(prev_s),
    .cur (cur_s),
    .row (row1_r),
    .hit (span_hit_s)
  );

`ifdef WAVE_DISPLAY_GRID_EN
  logic grid0_s;
  logic grid1_r;

  assign grid0_s = (bus.x[5:0] == 6'd0) || (bus.y[5:0] == 6'd0);
  dffr #(.WIDTH(1)) u_grid1 (.clk(clk), .r(reset), .d(grid0_s), .q(grid1_r));
`else
  // Grid-only inputs have no consumer in this build.
  logic unused_grid_s;
  assign unused_grid_s = ^{bus.x[0], bus.y[0], GRID_COLOR};
`endif

  // pixel color: trace wins over grid, everything else black
  always_comb begin
    color_s = 24'h000000;
    if (region1_r && span_hit_s) begin
      color_s = WAVE_COLOR;
`ifdef WAVE_DISPLAY_GRID_EN
    end else if (region1_r && grid1_r) begin
      color_s = GRID_COLOR;
`endif
    end else begin
      color_s = 24'h000000;
    end
  end

  dffr #(.WIDTH(24)) u_color (.clk(clk), .r(reset), .d(color_s),  .q(color_r));
  dffr #(.WIDTH(1))  u_vpix  (.clk(clk), .r(reset), .d(valid1_r), .q(valid_pixel_r));

  assign bus.valid_pixel = valid_pixel_r;
  assign bus.r           = color_r[23:16];
  assign bus.g           = color_r[15:8];
  assign bus.b           = color_r[7:0];

endmodule

// File: doc/wave_display.md
# wave_display

Reader-side counterpart of the wave capture block. Scans the idle half of the 512×8 double-buffered sample RAM in step with the VGA raster and plots the stored waveform as a connected trace in the top-right display quadrant. Emits `wave_display_idle` so the capture side may swap buffers only while no wave rows are being drawn.

## Interface

**Parameters**
- `WAVE_COLOR`, default 24'hFFFFFF: {r,g,b} of trace pixels.
- `GRID_COLOR`, default 24'h404040: {r,g,b} of grid pixels (only with the grid macro).

**Ports** (one clock; reset is synchronous and active-high)
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `x` in 11: raster column from the VGA controller.
- `y` in 10: raster row.
- `valid` in 1: x/y address a visible pixel this cycle.
- `read_index` in 1: buffer currently being written by capture. The display reads `~read_index`.
- `read_value` in 8: RAM data, offset-binary, valid one cycle after `read_address`.
- `read_address` out 9: {buffer, column}.
- `valid_pixel` out 1: r/g/b are meaningful this cycle.
- `r`, `g`, `b` out 8 each: pixel color.
- `wave_display_idle` out 1: no wave row is being scanned.

## Operation

**Region**
- `in_region` = valid && x[10:9]==2'b01 && y[9]==0.
- column = x[8:1], so each sample is two pixels wide.
- row = y[8:1].

**FSM** (2 states)
- IDLE → DRAW when `in_region`. On entry, latch `buf = ~read_index`.
- DRAW → IDLE when valid && y[9]==1 (raster left the top half).
- `buf` is held constant in DRAW. A `read_index` toggle during DRAW has no effect until the next IDLE→DRAW.
- `wave_display_idle` = (state==IDLE), registered.

**Read**
- `read_address = {buf, column}` when in DRAW, else {buf, 8'd0}.

**Samples**
- `cur` = displayed value = ~read_value (255 − value), so larger samples appear higher on screen.
- `prev` updates to the old `cur` whenever the stage-1 column differs from the last column seen.
- At column 0, `prev` := `cur`, so the trace does not wrap from column 255.

**Plot**
- Trace pixel when stage-2 `in_region` and min(prev,cur) ≤ row ≤ max(prev,cur). Unsigned 8-bit compare, no extension.
- Trace → {r,g,b}=WAVE_COLOR.
- Otherwise (grid off) → 0.

**Outputs**
- `valid_pixel` = stage-2 `valid`.

## Timing

- Stage 0: x/y/valid registered, address driven.
- Stage 1: `read_value` arrives, `cur`/`prev` update.
- Stage 2: r/g/b/`valid_pixel` registered.
- Latency: x/y/valid → r/g/b/`valid_pixel` is exactly 2 cycles.
- `wave_display_idle` asserts 1 cycle after the DRAW→IDLE condition and deasserts 1 cycle after `in_region`.
- Reset values: state IDLE, `wave_display_idle`=1, `read_address`=0, `valid_pixel`=0, r/g/b=0, prev/cur=0, buf=0.
- Reset mid-DRAW: IDLE on the next edge; pipeline outputs zero the following cycle.
- `valid` low within region: no state change, outputs r/g/b=0, `valid_pixel`=0.

## Configuration

- `WAVE_DISPLAY_GRID_EN` defined: in-region non-trace pixels with x[5:0]==0 or y[5:0]==0 output GRID_COLOR. Trace color has priority over grid.
- Macro undefined: no grid logic is compiled; non-trace pixels are 0.

## Structure

- Shared package holds:
  - state encodings IDLE=1'b0, DRAW=1'b1;
  - region constants (quadrant x[10:9]=2'b01, y[9]=0);
  - default colors.
- All registers use the existing `dffr`/`dffre` flops.
- One sub-module, `wave_display_span_cmp`: combinational min/max/between test on (prev, cur, row).

## Test plan

- After reset, with valid=0 → idle=1, `valid_pixel`=0, r/g/b=0, `read_address`=0.
- read_index=0; RAM buf1 filled with constant 8'h80 (cur=0x7F); scan row y=254 across the quadrant → trace pixel only on that row, pixels appear 2 cycles after each x.
- Step sample 0x00→0xFF between columns 10 and 11 → column 11 lights all rows 0..255 (vertical connector).
- Toggle read_index mid-frame (row y=100) → `read_address[8]` unchanged until y leaves the region and re-enters. Idle goes 1 at y=512 and back to 0 at the next frame's y=0.
- Column 0 with prev from column 255 = 0x00 and cur = 0xFF → single pixel at row 0xFF only (no wrap line).
- Assert reset during DRAW → idle=1 next cycle, r/g/b=0 and `valid_pixel`=0 after the flush. With `WAVE_DISPLAY_GRID_EN` defined, pixel (x=576, y=3) → GRID_COLOR.
